// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the HI/LO multiply/divide engine:
//   - ALU-decoder control codes consumed by muldiv_unit
//   - state encoding of the muldiv_unit sequencer
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    // Control codes emitted by the ALU decoder. MULT/MULTU and DIV/DIVU share a
    // code; signedness travels separately on signed_i.
    localparam logic [4:0] MULT_CONTROL = 5'b11000;
    localparam logic [4:0] DIV_CONTROL  = 5'b11001;
    localparam logic [4:0] MTHI_CONTROL = 5'b11010;
    localparam logic [4:0] MTLO_CONTROL = 5'b11011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit_div_radix2.sv
// -----------------------------------------------------------------------------
// div_radix2
// Iterative restoring divider on unsigned magnitudes, one quotient bit per
// cycle, WIDTH iterations after the start cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_start         load operands (cycle T); iterations run T+1..T+WIDTH
//   i_abort         drop the operation in flight
//   i_dividend      unsigned dividend
//   i_divisor       unsigned divisor (0 yields all-ones quotient)
//   o_busy          iterations in progress
//   o_done          final iteration is executing this cycle; o_quotient and
//                   o_remainder hold the result from the next cycle on
//   o_quotient      quotient register
//   o_remainder     partial / final remainder register
// -----------------------------------------------------------------------------
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;

    logic [WIDTH:0]   w_rem_sh;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_next;

    // Shift the next dividend bit (MSB of the quotient register) into the
    // partial remainder. The shifted value needs one extra bit, but the
    // subtraction result is always < divisor, so WIDTH bits hold it.
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_fits     = (w_rem_sh >= {1'b0, r_div});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_div;
    assign w_rem_next = w_fits ? w_diff : w_rem_sh[WIDTH-1:0];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are cleared too, so a reset mid-divide
            // leaves no stale partial result visible anywhere.
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_div  <= i_divisor;
        end else if (r_busy) begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_busy & (r_cnt == CNT_W'(WIDTH - 1));
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Execute-stage HI/LO engine: pipelined multiply, 32-step radix-2 divide,
// MTHI/MTLO writes, and the architectural HI/LO registers.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush_i        abort current op, no HI/LO write
//   valid_i        EX stage holds a valid instruction
//   alucontrol_i   decoded ALU control code (see muldiv_unit_pkg)
//   signed_i       1 = MULT/DIV, 0 = MULTU/DIVU
//   a_i, b_i       rs / rt operands
//   stall_o        hold IF..EX (combinational)
//   done_o         one-cycle pulse while in DONE
//   hi_o, lo_o     registered HI / LO
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [4:0]       alucontrol_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    muldiv_state_e    r_state;
    muldiv_state_e    w_state_next;

    logic [7:0]       r_mul_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic             r_op_mul;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_idle_ok;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_start;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [2*WIDTH-1:0] w_mul_a;
    logic [2*WIDTH-1:0] w_mul_b;
    logic [2*WIDTH-1:0] w_prod;
    logic             w_div_busy;
    logic             w_div_done;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic             w_q_neg;
    logic             w_r_neg;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    // Instruction acceptance (MULT/DIV start and MTHI/MTLO) only from IDLE.
    assign w_idle_ok = valid_i & ~flush_i & (r_state == ST_IDLE);
    assign w_is_mul  = (alucontrol_i == MULT_CONTROL);
    assign w_is_div  = (alucontrol_i == DIV_CONTROL);
    assign w_start   = w_idle_ok & (w_is_mul | w_is_div);

    // Divider works on magnitudes taken straight from the operand ports in the
    // start cycle; it latches them itself. -0x80000000 wraps to 0x80000000,
    // which is the correct unsigned magnitude.
    assign w_a_mag = (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_b_mag = (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;

    div_radix2 #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start & w_is_div),
        .i_abort     (flush_i),
        .i_dividend  (w_a_mag),
        .i_divisor   (w_b_mag),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Sign-extending both operands to 2*WIDTH makes the low 2*WIDTH bits of a
    // plain unsigned product equal the signed or unsigned full product.
    assign w_mul_a = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
    assign w_mul_b = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_mul_a * w_mul_b;

    // Divide sign fix-up and the divide-by-zero override.
    assign w_q_neg    = r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_r_neg    = r_signed & r_a[WIDTH-1];
    assign w_div_zero = (r_b == '0);
    assign w_div_lo   = w_div_zero ? '1  : (w_q_neg ? -w_quo : w_quo);
    assign w_div_hi   = w_div_zero ? r_a : (w_r_neg ? -w_rem : w_rem);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and control outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        w_state_next = r_state;
        stall_o      = 1'b0;
        done_o       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = w_is_mul ? ST_MUL : ST_DIV;
                end
            end
            ST_MUL: begin
                if (r_mul_cnt == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DIV: begin
                // Leaving on a lost divider (not busy) keeps the FSM from
                // ever waiting on an op that no longer exists.
                if (w_div_done || !w_div_busy) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                done_o       = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (flush_i) begin
            w_state_next = ST_IDLE;
        end

        stall_o = ~flush_i & (w_start | (r_state == ST_MUL) | (r_state == ST_DIV));
    end

    // Operand latch, multiply pipeline and multiply cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_op_mul  <= 1'b0;
            r_prod    <= '0;
            r_mul_cnt <= '0;
        end else begin
            if (w_start) begin
                r_a       <= a_i;
                r_b       <= b_i;
                r_signed  <= signed_i;
                r_op_mul  <= w_is_mul;
                r_mul_cnt <= 8'(MUL_LAT - 1);
            end
            if (r_state == ST_MUL) begin
                r_prod <= w_prod;
                if (r_mul_cnt != '0) begin
                    r_mul_cnt <= r_mul_cnt - 1'b1;
                end
            end
        end
    end

    // Architectural HI/LO. Results commit at the DONE edge unless flushed;
    // MTHI/MTLO commit in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if ((r_state == ST_DONE) && !flush_i) begin
            if (r_op_mul) begin
                r_hi <= r_prod[2*WIDTH-1:WIDTH];
                r_lo <= r_prod[WIDTH-1:0];
            end else begin
                r_hi <= w_div_hi;
                r_lo <= w_div_lo;
            end
        end else if (w_idle_ok) begin
            if (alucontrol_i == MTHI_CONTROL) begin
                r_hi <= a_i;
            end
            if (alucontrol_i == MTLO_CONTROL) begin
                r_lo <= a_i;
            end
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Execute-stage HI/LO engine that consumes the 5-bit alucontrol codes produced by the ALU decoder: MULT_CONTROL, DIV_CONTROL, MTHI_CONTROL and MTLO_CONTROL. It runs a pipelined multiply and a 32-iteration radix-2 divide. While an operation is in flight it stalls the pipeline, and it owns the architectural HI/LO registers. Signedness arrives separately on signed_i, because MULT/MULTU and DIV/DIVU share control codes.

Parameters:
WIDTH, 32, operand and HI/LO width
MUL_LAT, 2, multiply busy cycles after accept (>=1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
flush_i  in  1  exception/branch flush; aborts current op
valid_i  in  1  EX stage holds a valid instruction
alucontrol_i  in  5  decoded ALU control code
signed_i  in  1  1 = MULT/DIV, 0 = MULTU/DIVU
a_i  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
b_i  in  WIDTH  rt operand (divisor / multiplier)
stall_o  out  1  hold IF..EX; combinational
done_o  out  1  one-cycle pulse in DONE state
hi_o  out  WIDTH  registered HI
lo_o  out  WIDTH  registered LO

Behaviour:
- Reset: state IDLE; hi_o=0, lo_o=0, done_o=0, stall_o=0; counters and datapath registers cleared.
- States: IDLE, MUL, DIV, DONE.
- start = valid_i & ~flush_i & state==IDLE & alucontrol_i in {MULT_CONTROL, DIV_CONTROL}.
- stall_o = ~flush_i & (start | state==MUL | state==DIV).
- stall_o is 0 in DONE, so the pipeline advances in that cycle.
- Operands are latched on start. Later changes to a_i/b_i are ignored.
- IDLE -> MUL on start with MULT. Stay in MUL for MUL_LAT cycles, then go to DONE.
  - Accept at cycle T: stall_o is high T..T+MUL_LAT; DONE is at T+MUL_LAT+1.
- IDLE -> DIV on start with DIV. Run 32 iterations at 1 bit/cycle, then go to DONE.
  - Accept at cycle T: stall_o is high T..T+32; DONE is at T+33.
- DONE -> IDLE unconditionally.
  - A valid_i still presented in DONE (the same instruction) must not restart.
  - {hi,lo} is written at the DONE edge and is visible the cycle after DONE.
- Multiply: full 2*WIDTH product, signed or unsigned. hi = upper half, lo = lower half.
- Divide sign rules:
  - Divide on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). Both apply only when signed_i.
  - lo = quotient, hi = remainder.
- Divide boundary cases:
  - Divide by zero, any signedness: full latency, lo=all ones, hi=a (raw).
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - Applies when valid_i & ~flush_i & state==IDLE. Write hi (or lo) = a_i at the edge.
  - No stall and no done_o.
  - In non-IDLE states MTHI/MTLO are not accepted. The pipeline is already stalled there, so they cannot arrive.
- Flush:
  - flush_i in any state returns the unit to IDLE at the next edge.
  - stall_o drops in the same cycle.
  - No HI/LO write, including when the flush lands in DONE (done_o still pulses but the write is suppressed).
- Any other alucontrol code: ignored, no state change.
- rst mid-operation: outputs return to reset values at the next edge and the in-flight op is discarded.

Decomposition:
- Control-code constants stay in the shared defines2.vh header.
- Add the MULDIV state encodings to defines2.vh.
- One natural sub-module, div_radix2: the iterative restoring divider with start/abort/busy/done and quotient/remainder outputs.
- Sign fix-up and the multiply pipeline stay in the parent.

Test Plan:
1. MULT, signed_i=1, a=0xFFFFFFFE, b=3, MUL_LAT=2 -> stall_o high 3 cycles; after DONE, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. DIVU, a=100, b=7 -> stall_o high exactly 33 cycles; done_o one pulse; lo=14, hi=2.
3. DIV signed, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIV a=0x12345678, b=0 -> full 33-cycle stall; lo=0xFFFFFFFF, hi=0x12345678.
5. Pre-load via MTHI 0xAAAA0000; start DIVU; assert flush_i at busy cycle 10 -> stall_o drops that cycle; hi stays 0xAAAA0000; an MTLO 0x5 the next cycle is accepted, lo=0x5.
6. rst asserted mid-DIV, plus rst during MUL -> hi_o=lo_o=0, stall_o=0 after the edge; a new MULTU 0xFFFFFFFF*0xFFFFFFFF then gives hi=0xFFFFFFFE, lo=0x00000001.
